timekeeper_core: RTL and testbench
==================================

# timekeeper_core

Parametrised time-of-day core: a sub-second prescaler feeding cascaded second/minute/hour counters, a set mode with a cursor-selected field, 12/24-hour output formatting and a minute-resolution alarm. It folds the separate prescaler, counter and control blocks of the current clock into one generalised block with configurable tick rate and reset time. It sits between the debounced button front-end and the display driver.

## Interface
- TICKS_PER_SEC, 1000: clock cycles per second; legal range ≥2.
- RESET_HR, 0: hour loaded at reset; legal range 0–23.
- RESET_MIN, 0: minute loaded at reset; legal range 0–59.
- RESET_SEC, 0: second loaded at reset; legal range 0–59.
- i_clk  in  1  single clock; all state on rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_set  in  1  pulse; toggles run/set mode.
- i_up, i_down  in  1 each  pulses; adjust the selected field in set mode.
- i_left, i_right  in  1 each  pulses; move the field cursor in set mode.
- i_mode12  in  1  1 = 12-hour output format, 0 = 24-hour.
- i_alarm_en  in  1  alarm enable.
- i_alarm_hr  in  5  alarm hour, 24-hour encoding.
- i_alarm_min  in  6  alarm minute.
- o_sec  out  6  seconds, 0–59.
- o_min  out  6  minutes, 0–59.
- o_hr  out  5  hour, formatted per i_mode12.
- o_pm  out  1  1 when the internal hour is ≥12; valid in both formats.
- o_setting  out  1  1 while in set mode.
- o_field  out  2  cursor: 0 = sec, 1 = min, 2 = hr.
- o_sec_tick  out  1  one-cycle pulse when seconds advance in run mode.
- o_alarm  out  1  one-cycle alarm pulse.

## Operation
- Input pulses are sampled every cycle; an input held high acts on every cycle it is high.
- Reset values: sec/min/hr = RESET_*, prescaler 0, o_setting 0, o_field 0, o_sec_tick 0, o_alarm 0.
- Internal hour is always kept 0–23.
- Run mode:
  - The prescaler counts 0..TICKS_PER_SEC-1 and wraps.
  - At the terminal count, sec increments: 59→0 carries into min, min 59→0 carries into hr, hr 23→0.
  - A full cascade wraps 23:59:59→00:00:00.
  - i_up, i_down, i_left and i_right are ignored.
- i_set in run mode: enter set mode on the next edge.
  - o_field is set to 0 on entry.
  - The prescaler is cleared and held at 0 for the whole of set mode.
  - If the terminal count coincides with i_set, that second's increment still occurs on the same edge.
- Set mode:
  - The time is frozen; no o_sec_tick.
  - i_up and i_down increment or decrement the selected field, wrapping within that field only (sec/min 0↔59, hr 0↔23). They never carry into or borrow from another field.
  - i_up and i_down in the same cycle: no change.
  - i_left moves the cursor toward more significant fields (0→1→2→0); i_right moves it the other way (0→2→1→0).
  - i_left and i_right in the same cycle: no cursor change.
  - An adjust and a cursor move in the same cycle: the adjust applies to the field selected before the move.
  - i_set in set mode: return to run mode. Adjust and cursor inputs in that same cycle are still applied. The prescaler restarts from 0, so the first tick comes TICKS_PER_SEC cycles after exit.
- 12/24-hour format (combinational from the registered hour):
  - i_mode12 = 0: o_hr = internal hour.
  - i_mode12 = 1: o_hr = 12 when the internal hour is 0 or 12, otherwise the internal hour mod 12.
  - o_pm = (internal hour ≥ 12) in both formats.
- Alarm: o_alarm pulses for one cycle when i_alarm_en = 1 and a run-mode increment makes hr = i_alarm_hr, min = i_alarm_min and sec = 0.
  - Changes made in set mode never fire the alarm.
  - i_alarm_hr > 23 or i_alarm_min > 59 never fires.
- Reset mid-operation (any mode, any cycle): all state returns to its reset value immediately.

## Timing
- o_sec, o_min, o_hr (24-hour format), o_setting, o_field, o_sec_tick and o_alarm are registered.
- o_hr in 12-hour format and o_pm are combinational from registered state only; there is no input-to-output combinational path except i_mode12 → o_hr.
- After reset release, the first sec increment happens on the TICKS_PER_SEC-th rising edge; increments then repeat every TICKS_PER_SEC cycles.
- o_sec_tick and o_alarm assert in the same cycle the new time value appears on the outputs.
- Set-mode adjustments and cursor moves are visible one cycle after the input pulse.

## Test plan
- TICKS_PER_SEC = 4, reset 23:59:58, run 8 cycles → 23:59:59 after edge 4, then 00:00:00 after edge 8; o_sec_tick high in exactly those two cycles.
- Pulse i_set, then i_left ×2, i_up ×3 from 10:20:30 → o_field = 2, o_hr = 13; pulse i_down ×14 → o_hr = 23. Min and sec unchanged throughout; no ticks for 20 cycles.
- Set mode with field = 0 at sec = 59, i_up → sec = 0 and min unchanged; i_up and i_down in the same cycle → no change; i_left and i_right in the same cycle → o_field unchanged.
- Internal hours 0, 11, 12 and 13 with i_mode12 = 1 → o_hr = 12, 11, 12, 1 and o_pm = 0, 0, 1, 1; with i_mode12 = 0 → o_hr = 0, 11, 12, 13.
- Alarm set to 07:00, enabled:
  - Run from 06:59:58 → o_alarm pulses once, in the cycle 07:00:00 appears.
  - Set 07:00:00 by hand in set mode → no pulse.
  - Same run with i_alarm_en = 0 → no pulse.
- Assert i_rstn low mid set-mode and mid-cascade → all outputs return to reset values immediately; after release the first tick arrives exactly TICKS_PER_SEC edges later.

Source files
------------

// File: rtl/timekeeper_core.sv
// timekeeper_core
// Time-of-day core: a sub-second prescaler drives cascaded sec/min/hr
// counters. A set mode freezes the time and lets a cursor-selected field be
// adjusted. The core also provides 12/24-hour output formatting and a
// minute-resolution alarm.
//
// Ports:
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   i_set                    toggles run/set mode
//   i_up, i_down             adjust selected field (set mode only)
//   i_left, i_right          move field cursor (set mode only)
//   i_mode12                 1 = 12-hour o_hr format, 0 = 24-hour
//   i_alarm_en/hr/min        alarm enable and time (24-hour hour encoding)
//   o_sec, o_min, o_hr       current time (o_hr formatted per i_mode12)
//   o_pm                     internal hour >= 12
//   o_setting, o_field       set mode flag and cursor (0 sec, 1 min, 2 hr)
//   o_sec_tick, o_alarm      one-cycle pulses, aligned with the new time
//
// All control inputs are level-sampled every cycle. A pulse held high acts
// on every cycle it is high, so there is no handshake and no edge detection.
module timekeeper_core #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int RESET_HR      = 0,
  parameter int RESET_MIN     = 0,
  parameter int RESET_SEC     = 0
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_set,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_mode12,
  input  logic       i_alarm_en,
  input  logic [4:0] i_alarm_hr,
  input  logic [5:0] i_alarm_min,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hr,
  output logic       o_pm,
  output logic       o_setting,
  output logic [1:0] o_field,
  output logic       o_sec_tick,
  output logic       o_alarm
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_SET = 1'b1
  } mode_t;

  mode_t         mode;
  logic [PW-1:0] presc;
  logic [5:0]    sec_q;
  logic [5:0]    min_q;
  logic [4:0]    hr_q;
  logic [1:0]    field_q;
  logic          sec_tick_q;
  logic          alarm_q;

  // Run-mode cascade: the value the time takes if this cycle is a tick.
  logic       terminal;
  logic       sec_wrap;
  logic       min_wrap;
  logic [5:0] inc_sec;
  logic [5:0] inc_min;
  logic [4:0] inc_hr;
  logic       alarm_hit;

  always_comb begin
    terminal  = (mode == MODE_RUN) && (presc == TERM);
    sec_wrap  = (sec_q == 6'd59);
    min_wrap  = sec_wrap && (min_q == 6'd59);
    inc_sec   = sec_wrap ? 6'd0 : sec_q + 6'd1;
    inc_min   = sec_wrap ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1) : min_q;
    inc_hr    = min_wrap ? ((hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1) : hr_q;
    // Out-of-range alarm settings can never match a legal time, so they
    // never fire without any extra range check.
    alarm_hit = i_alarm_en && (inc_hr == i_alarm_hr) &&
                (inc_min == i_alarm_min) && (inc_sec == 6'd0);
  end

  // Set-mode adjust: wraps within the selected field, never carries.
  // The adjust uses the cursor position from before any move this cycle.
  logic       up_only;
  logic       down_only;
  logic       left_only;
  logic       right_only;
  logic [5:0] adj_sec;
  logic [5:0] adj_min;
  logic [4:0] adj_hr;
  logic [1:0] nxt_field;

  always_comb begin
    up_only    = i_up & ~i_down;
    down_only  = i_down & ~i_up;
    left_only  = i_left & ~i_right;
    right_only = i_right & ~i_left;
    adj_sec    = sec_q;
    adj_min    = min_q;
    adj_hr     = hr_q;
    nxt_field  = field_q;
    if (up_only) begin
      case (field_q)
        2'd0:    adj_sec = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
        2'd1:    adj_min = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        2'd2:    adj_hr  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        default: begin end
      endcase
    end else if (down_only) begin
      case (field_q)
        2'd0:    adj_sec = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
        2'd1:    adj_min = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
        2'd2:    adj_hr  = (hr_q == 5'd0) ? 5'd23 : hr_q - 5'd1;
        default: begin end
      endcase
    end
    if (left_only) begin
      nxt_field = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
    end else if (right_only) begin
      nxt_field = (field_q == 2'd0) ? 2'd2 : field_q - 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mode       <= MODE_RUN;
      presc      <= '0;
      sec_q      <= 6'(RESET_SEC);
      min_q      <= 6'(RESET_MIN);
      hr_q       <= 5'(RESET_HR);
      field_q    <= 2'd0;
      sec_tick_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      case (mode)
        MODE_RUN: begin
          sec_tick_q <= terminal;
          alarm_q    <= terminal && alarm_hit;
          if (terminal) begin
            presc <= '0;
            sec_q <= inc_sec;
            min_q <= inc_min;
            hr_q  <= inc_hr;
          end else begin
            presc <= presc + PW'(1);
          end
          // A coincident tick above still lands; only the prescaler is
          // overridden so set mode starts from a clean count.
          if (i_set) begin
            mode    <= MODE_SET;
            field_q <= 2'd0;
            presc   <= '0;
          end
        end
        MODE_SET: begin
          presc      <= '0;
          sec_tick_q <= 1'b0;
          alarm_q    <= 1'b0;
          sec_q      <= adj_sec;
          min_q      <= adj_min;
          hr_q       <= adj_hr;
          field_q    <= nxt_field;
          if (i_set) begin
            mode <= MODE_RUN;
          end
        end
        default: mode <= MODE_RUN;
      endcase
    end
  end

  // 12-hour view: 0 and 12 both show as 12.
  logic [4:0] hr12;
  always_comb begin
    if (hr_q == 5'd0 || hr_q == 5'd12) begin
      hr12 = 5'd12;
    end else if (hr_q > 5'd12) begin
      hr12 = hr_q - 5'd12;
    end else begin
      hr12 = hr_q;
    end
  end

  assign o_sec      = sec_q;
  assign o_min      = min_q;
  assign o_hr       = i_mode12 ? hr12 : hr_q;
  assign o_pm       = (hr_q >= 5'd12);
  assign o_setting  = (mode == MODE_SET);
  assign o_field    = field_q;
  assign o_sec_tick = sec_tick_q;
  assign o_alarm    = alarm_q;

endmodule

// File: tb/tb_timekeeper_core.sv
// tb_timekeeper_core
// Bench for timekeeper_core with TICKS_PER_SEC = 4 and reset time 23:59:58.
// A reference model keeps the time as seconds-since-midnight plus a count of
// run-mode cycles since the last second. The model is compared every cycle.
// Hand-computed vector tables and sequences cover the corner cases.
module tb_timekeeper_core;

  localparam int TPS = 4;
  localparam int RST_T = 23 * 3600 + 59 * 60 + 58;

  // ---------------- clock / reset ----------------
  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b1;
  logic       i_set = 1'b0, i_up = 1'b0, i_down = 1'b0;
  logic       i_left = 1'b0, i_right = 1'b0;
  logic       i_mode12 = 1'b0, i_alarm_en = 1'b0;
  logic [4:0] i_alarm_hr = 5'd0;
  logic [5:0] i_alarm_min = 6'd0;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hr;
  logic [1:0] o_field;
  logic       o_pm, o_setting, o_sec_tick, o_alarm;

  always #5 i_clk = ~i_clk;

  timekeeper_core #(
    .TICKS_PER_SEC(TPS), .RESET_HR(23), .RESET_MIN(59), .RESET_SEC(58)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_set(i_set), .i_up(i_up),
    .i_down(i_down), .i_left(i_left), .i_right(i_right),
    .i_mode12(i_mode12), .i_alarm_en(i_alarm_en), .i_alarm_hr(i_alarm_hr),
    .i_alarm_min(i_alarm_min), .o_sec(o_sec), .o_min(o_min), .o_hr(o_hr),
    .o_pm(o_pm), .o_setting(o_setting), .o_field(o_field),
    .o_sec_tick(o_sec_tick), .o_alarm(o_alarm)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int tick_seen = 0;
  int alarm_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_t;        // seconds since midnight
  int m_phase;    // run-mode cycles since the last second
  bit m_set_mode;
  int m_field;
  bit m_tick, m_alarm;

  function automatic void model_reset();
    m_t = RST_T; m_phase = 0; m_set_mode = 0; m_field = 0;
    m_tick = 0; m_alarm = 0;
  endfunction

  function automatic void model_step(input bit s, u, d, l, r);
    int h, mi, se, adj, mv;
    m_tick = 0; m_alarm = 0;
    if (!m_set_mode) begin
      m_phase++;
      if (m_phase == TPS) begin
        m_phase = 0;
        m_t = (m_t + 1) % 86400;
        m_tick = 1;
        if (i_alarm_en && int'(i_alarm_hr) < 24 && int'(i_alarm_min) < 60 &&
            m_t == int'(i_alarm_hr) * 3600 + int'(i_alarm_min) * 60)
          m_alarm = 1;
      end
      if (s) begin m_set_mode = 1; m_field = 0; m_phase = 0; end
    end else begin
      adj = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
      h = m_t / 3600; mi = (m_t / 60) % 60; se = m_t % 60;
      case (m_field)
        0: se = (se + adj + 60) % 60;
        1: mi = (mi + adj + 60) % 60;
        default: h = (h + adj + 24) % 24;
      endcase
      m_t = h * 3600 + mi * 60 + se;
      mv = (l && !r) ? 1 : ((r && !l) ? -1 : 0);
      m_field = (m_field + mv + 3) % 3;
      if (s) begin m_set_mode = 0; m_phase = 0; end
    end
  endfunction

  function automatic int exp_hr();
    int h = m_t / 3600;
    if (i_mode12) return (h % 12 == 0) ? 12 : h % 12;
    return h;
  endfunction

  task automatic compare_model();
    chk("model sec", int'(o_sec), m_t % 60);
    chk("model min", int'(o_min), (m_t / 60) % 60);
    chk("model hr", int'(o_hr), exp_hr());
    chk("model pm", int'(o_pm), int'(m_t >= 12 * 3600));
    chk("model setting", int'(o_setting), int'(m_set_mode));
    chk("model field", int'(o_field), m_field);
    chk("model sec_tick", int'(o_sec_tick), int'(m_tick));
    chk("model alarm", int'(o_alarm), int'(m_alarm));
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; inputs are held for exactly one edge.
  task automatic step(input bit s, u, d, l, r);
    i_set = s; i_up = u; i_down = d; i_left = l; i_right = r;
    model_step(s, u, d, l, r);
    @(posedge i_clk);
    #1;
    compare_model();
    if (o_sec_tick) tick_seen++;
    if (o_alarm) alarm_seen++;
    i_set = 0; i_up = 0; i_down = 0; i_left = 0; i_right = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Walks the DUT to h:m:s through set mode using up pulses only.
  task automatic set_time(input int h, input int m, input int s, input bit stay);
    if (!m_set_mode) step(1, 0, 0, 0, 0);
    while (m_field != 0) step(0, 0, 0, 0, 1);
    while (m_t % 60 != s) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    while ((m_t / 60) % 60 != m) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    while (m_t / 3600 != h) step(0, 1, 0, 0, 0);
    if (!stay) step(1, 0, 0, 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " rst sec"}, int'(o_sec), 58);
    chk({tag, " rst min"}, int'(o_min), 59);
    chk({tag, " rst hr"}, int'(o_hr), 23);
    chk({tag, " rst setting"}, int'(o_setting), 0);
    chk({tag, " rst field"}, int'(o_field), 0);
    chk({tag, " rst sec_tick"}, int'(o_sec_tick), 0);
    chk({tag, " rst alarm"}, int'(o_alarm), 0);
  endtask

  // Asserts reset between edges, checks the immediate effect, releases it,
  // and measures the edges until the first tick.
  task automatic reset_mid(input string tag);
    int n;
    i_rstn = 1'b0;
    #1;
    check_reset_values(tag);
    model_reset();
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    tick_seen = 0;
    n = 0;
    while (tick_seen == 0 && n < 3 * TPS) begin
      idle(1);
      n++;
    end
    chk({tag, " first tick edge"}, n, TPS);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit s, u, d, l, r;
    int sec, mn, hr;
    bit st;
    int fld;
    bit tk;
  } vec_t;

  vec_t tbl[26];

  initial begin
    int hrs[4];
    int e12[4];
    int epm[4];
    hrs = '{0, 11, 12, 13};
    e12 = '{12, 11, 12, 1};
    epm = '{0, 0, 1, 1};

    //          s u d l r  sec min hr st fld tk
    tbl[0]  = '{0,0,0,0,0, 58, 59, 23, 0, 0, 0};
    tbl[1]  = '{0,0,0,0,0, 58, 59, 23, 0, 0, 0};
    tbl[2]  = '{0,0,0,0,0, 58, 59, 23, 0, 0, 0};
    tbl[3]  = '{0,0,0,0,0, 59, 59, 23, 0, 0, 1};
    tbl[4]  = '{0,0,0,0,0, 59, 59, 23, 0, 0, 0};
    tbl[5]  = '{0,0,0,0,0, 59, 59, 23, 0, 0, 0};
    tbl[6]  = '{0,0,0,0,0, 59, 59, 23, 0, 0, 0};
    tbl[7]  = '{0,0,0,0,0,  0,  0,  0, 0, 0, 1};
    tbl[8]  = '{1,0,0,0,0,  0,  0,  0, 1, 0, 0};
    tbl[9]  = '{0,1,0,0,0,  1,  0,  0, 1, 0, 0};
    tbl[10] = '{0,1,1,0,0,  1,  0,  0, 1, 0, 0};
    tbl[11] = '{0,0,0,1,1,  1,  0,  0, 1, 0, 0};
    tbl[12] = '{0,0,1,0,0,  0,  0,  0, 1, 0, 0};
    tbl[13] = '{0,0,1,0,0, 59,  0,  0, 1, 0, 0};
    tbl[14] = '{0,1,0,0,0,  0,  0,  0, 1, 0, 0};
    tbl[15] = '{0,0,0,1,0,  0,  0,  0, 1, 1, 0};
    tbl[16] = '{0,0,1,0,0,  0, 59,  0, 1, 1, 0};
    tbl[17] = '{0,0,0,1,0,  0, 59,  0, 1, 2, 0};
    tbl[18] = '{0,0,1,0,0,  0, 59, 23, 1, 2, 0};
    tbl[19] = '{0,1,0,0,1,  0, 59,  0, 1, 1, 0};
    tbl[20] = '{0,0,0,1,0,  0, 59,  0, 1, 2, 0};
    tbl[21] = '{1,1,0,0,0,  0, 59,  1, 0, 2, 0};
    tbl[22] = '{0,0,0,0,0,  0, 59,  1, 0, 2, 0};
    tbl[23] = '{0,0,0,0,0,  0, 59,  1, 0, 2, 0};
    tbl[24] = '{0,0,0,0,0,  0, 59,  1, 0, 2, 0};
    tbl[25] = '{0,0,0,0,0,  1, 59,  1, 0, 2, 1};

    // Power-on reset: create a real falling edge on i_rstn.
    #2;
    i_rstn = 1'b0;
    #1;
    check_reset_values("por");
    model_reset();
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;

    // Cascade, set-mode adjust/cursor corners, and exit timing.
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].s, tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r);
      chk($sformatf("vec%0d sec", i), int'(o_sec), tbl[i].sec);
      chk($sformatf("vec%0d min", i), int'(o_min), tbl[i].mn);
      chk($sformatf("vec%0d hr", i), int'(o_hr), tbl[i].hr);
      chk($sformatf("vec%0d setting", i), int'(o_setting), int'(tbl[i].st));
      chk($sformatf("vec%0d field", i), int'(o_field), tbl[i].fld);
      chk($sformatf("vec%0d tick", i), int'(o_sec_tick), int'(tbl[i].tk));
    end

    // Hour adjust from 10:20:30 with the cursor on the hour field.
    set_time(10, 20, 30, 0);
    tick_seen = 0;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("hr field cursor", int'(o_field), 2);
    chk("hr after up x3", int'(o_hr), 13);
    for (int i = 0; i < 14; i++) step(0, 0, 1, 0, 0);
    chk("hr after down x14", int'(o_hr), 23);
    chk("min frozen", int'(o_min), 20);
    chk("sec frozen", int'(o_sec), 30);
    chk("no ticks in set", tick_seen, 0);
    step(1, 0, 0, 0, 0);

    // 12/24-hour formatting.
    for (int i = 0; i < 4; i++) begin
      set_time(hrs[i], 30, 0, 1);
      i_mode12 = 1'b1;
      #1;
      chk($sformatf("fmt12 hr%0d", hrs[i]), int'(o_hr), e12[i]);
      chk($sformatf("fmt12 pm%0d", hrs[i]), int'(o_pm), epm[i]);
      i_mode12 = 1'b0;
      #1;
      chk($sformatf("fmt24 hr%0d", hrs[i]), int'(o_hr), hrs[i]);
      chk($sformatf("fmt24 pm%0d", hrs[i]), int'(o_pm), epm[i]);
    end
    step(1, 0, 0, 0, 0);

    // Alarm at 07:00 reached by running.
    i_alarm_hr = 5'd7; i_alarm_min = 6'd0; i_alarm_en = 1'b1;
    set_time(6, 59, 58, 0);
    alarm_seen = 0;
    for (int i = 0; i < 3 * TPS; i++) begin
      idle(1);
      if (o_alarm) begin
        chk("alarm cycle hr", int'(o_hr), 7);
        chk("alarm cycle min", int'(o_min), 0);
        chk("alarm cycle sec", int'(o_sec), 0);
      end
    end
    chk("alarm pulses run", alarm_seen, 1);

    // Alarm time reached by hand in set mode: no pulse.
    alarm_seen = 0;
    set_time(7, 0, 0, 1);
    idle(3);
    step(1, 0, 0, 0, 0);
    chk("alarm pulses hand set", alarm_seen, 0);

    // Same run with the alarm disabled: no pulse.
    i_alarm_en = 1'b0;
    set_time(6, 59, 58, 0);
    alarm_seen = 0;
    idle(3 * TPS);
    chk("alarm pulses disabled", alarm_seen, 0);

    // Reset in the middle of set mode.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    reset_mid("setmode");

    // Reset right after a full cascade.
    set_time(23, 59, 59, 0);
    idle(TPS);
    chk("cascade tick", int'(o_sec_tick), 1);
    chk("cascade hr", int'(o_hr), 0);
    reset_mid("cascade");

    // Randomized run against the model.
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) begin
        i_alarm_en  = ($urandom_range(0, 3) != 0);
        i_alarm_hr  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                                  : 5'(m_t / 3600);
        i_alarm_min = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63))
                                                  : 6'(((m_t / 60) % 60 + $urandom_range(1, 2)) % 60);
      end
      i_mode12 = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
